// File: rtl/sensor_offset_calibrator_pkg.sv
// Shared definitions for the sensor offset calibrator.
//   cal_state_e : calibrator FSM state encoding
//   ch_lsb      : bit offset of channel k inside a packed NUM_CH*DATA_W bus
//   extend      : sign- or zero-extend a w-bit value to EXT_W bits
//   less_than   : a < b on w-bit values, signed or unsigned
package sensor_offset_calibrator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENABLE = 3'd1,
    ST_WARMUP = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_AVG    = 3'd4,
    ST_CHECK  = 3'd5,
    ST_FAIL   = 3'd6,
    ST_DONE   = 3'd7
  } cal_state_e;

  localparam int EXT_W = 64;

  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

  function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] v,
                                              input int w,
                                              input bit is_signed);
    logic [EXT_W-1:0] r;
    logic             fill;
    r    = v;
    fill = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      if (is_signed && (i == w - 1)) fill = v[i];
    end
    for (int i = 0; i < EXT_W; i++) begin
      if (i >= w) r[i] = fill;
    end
    return r;
  endfunction

  // Both operands are widened first, so a plain signed compare covers the
  // unsigned case too (zero-extended values are never negative).
  function automatic logic less_than(input logic [EXT_W-1:0] a,
                                     input logic [EXT_W-1:0] b,
                                     input int w,
                                     input bit is_signed);
    logic signed [EXT_W-1:0] ea;
    logic signed [EXT_W-1:0] eb;
    ea = extend(a, w, is_signed);
    eb = extend(b, w, is_signed);
    return ea < eb;
  endfunction

endpackage

// File: rtl/sensor_offset_calibrator_accum.sv
// One channel's block accumulator.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the accumulator
//   add          : add the extended sample this cycle
//   sample       : DATA_W-bit channel sample
//   avg          : accumulator divided by 2^LOG_DEPTH (floor)
module cal_channel_accum
  import sensor_offset_calibrator_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LOG_DEPTH   = 6,
  parameter int SIGNED_DATA = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg
);

  localparam int ACC_W = DATA_W + LOG_DEPTH;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sample_ext;

  assign sample_ext = ACC_W'(extend(EXT_W'(sample), DATA_W, SIGNED_DATA != 0));

  always_ff @(posedge clock) begin
    if (reset || clear) acc_q <= '0;
    else if (add)       acc_q <= acc_q + sample_ext;
  end

  // Dropping the low LOG_DEPTH bits of a two's-complement sum is an
  // arithmetic shift, i.e. floor division, for both signed and unsigned data.
  assign avg = acc_q[LOG_DEPTH +: DATA_W];

endmodule

// File: rtl/sensor_offset_calibrator.sv
// Zero-offset calibrator: enables a sensor, discards WARMUP sample sets,
// block-averages 2^LOG_DEPTH sets per channel, range-checks each average and
// publishes packed offsets with error flags.
//   clock, reset        : system clock, synchronous active-high reset
//   start               : run request, honoured in IDLE and DONE
//   en_sec              : one-second tick, drives the collection timeout
//   reset_1sec          : state is about to change (restarts the divider)
//   sensor_start/reset  : sensor enable and reset
//   sample_valid/data   : packed sample sets, channel k at [k*DATA_W +: DATA_W]
//   bound_lo/hi         : inclusive per-channel plausibility bounds
//   offsets(_valid)     : packed averages and their validity
//   busy, done          : run in progress / run finished
//   error_timeout/range : timeout flag, per-channel out-of-bounds flags
//
// state  | meaning
// IDLE   | sensor held in reset, waiting for start
// ENABLE | one cycle: sensor enabled, accumulators/counters/errors cleared
// WARMUP | discarding the first WARMUP sample sets
// ACCUM  | summing 2^LOG_DEPTH sample sets per channel
// AVG    | one cycle: averages loaded into offsets, sensor disabled
// CHECK  | one channel per cycle compared against its bounds
// FAIL   | one cycle: timeout recorded, sensor back in reset
// DONE   | results held until the next start
module sensor_offset_calibrator
  import sensor_offset_calibrator_pkg::*;
#(
  parameter int NUM_CH      = 6,
  parameter int DATA_W      = 16,
  parameter int LOG_DEPTH   = 6,
  parameter int WARMUP      = 8,
  parameter int TIMEOUT_SEC = 5,
  parameter int SIGNED_DATA = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     en_sec,
  output logic                     reset_1sec,
  output logic                     sensor_start,
  output logic                     sensor_reset,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic [NUM_CH*DATA_W-1:0] bound_lo,
  input  logic [NUM_CH*DATA_W-1:0] bound_hi,
  output logic [NUM_CH*DATA_W-1:0] offsets,
  output logic                     offsets_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     error_timeout,
  output logic [NUM_CH-1:0]        error_range
);

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int CNT_W  = (WARM_W > LOG_DEPTH + 1) ? WARM_W : LOG_DEPTH + 1;
  localparam int TMR_W  = (TIMEOUT_SEC < 1) ? 1 : $clog2(TIMEOUT_SEC + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  cal_state_e state_q, state_d;

  logic [CNT_W-1:0]         cnt_q;
  logic [TMR_W-1:0]         timer_q;
  logic [CH_W-1:0]          ch_idx_q;
  logic [NUM_CH*DATA_W-1:0] offsets_q;
  logic [NUM_CH*DATA_W-1:0] avg_all;
  logic                     offsets_valid_q;
  logic                     error_timeout_q;
  logic [NUM_CH-1:0]        error_range_q;
  logic [NUM_CH-1:0]        error_range_d;

  logic [DATA_W-1:0] off_ch [NUM_CH];
  logic [DATA_W-1:0] lo_ch  [NUM_CH];
  logic [DATA_W-1:0] hi_ch  [NUM_CH];

  logic warm_done, accum_last, timeout_hit, ch_last, out_of_range;
  logic acc_clear, acc_add;

  assign warm_done   = (WARMUP == 0) ||
                       (sample_valid && (cnt_q == CNT_W'(WARMUP - 1)));
  assign accum_last  = sample_valid && (cnt_q == CNT_W'((1 << LOG_DEPTH) - 1));
  // Fires on the tick that brings the timer to TIMEOUT_SEC.
  assign timeout_hit = en_sec && (timer_q == TMR_W'(TIMEOUT_SEC - 1));
  assign ch_last     = (ch_idx_q == CH_W'(NUM_CH - 1));

  assign acc_clear = (state_q == ST_ENABLE);
  assign acc_add   = (state_q == ST_ACCUM) && sample_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cal_channel_accum #(
      .DATA_W      (DATA_W),
      .LOG_DEPTH   (LOG_DEPTH),
      .SIGNED_DATA (SIGNED_DATA)
    ) u_accum (
      .clock  (clock),
      .reset  (reset),
      .clear  (acc_clear),
      .add    (acc_add),
      .sample (sample_data[ch_lsb(g, DATA_W) +: DATA_W]),
      .avg    (avg_all[ch_lsb(g, DATA_W) +: DATA_W])
    );
    assign off_ch[g] = offsets_q[ch_lsb(g, DATA_W) +: DATA_W];
    assign lo_ch[g]  = bound_lo[ch_lsb(g, DATA_W) +: DATA_W];
    assign hi_ch[g]  = bound_hi[ch_lsb(g, DATA_W) +: DATA_W];
  end

  assign out_of_range =
      less_than(EXT_W'(off_ch[ch_idx_q]), EXT_W'(lo_ch[ch_idx_q]), DATA_W, SIGNED_DATA != 0) ||
      less_than(EXT_W'(hi_ch[ch_idx_q]), EXT_W'(off_ch[ch_idx_q]), DATA_W, SIGNED_DATA != 0);

  always_comb begin
    error_range_d           = error_range_q;
    error_range_d[ch_idx_q] = out_of_range;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ENABLE;
      ST_ENABLE: state_d = ST_WARMUP;
      ST_WARMUP: begin
        if (timeout_hit)    state_d = ST_FAIL;
        else if (warm_done) state_d = ST_ACCUM;
      end
      // Completion beats a coinciding timeout.
      ST_ACCUM: begin
        if (accum_last)       state_d = ST_AVG;
        else if (timeout_hit) state_d = ST_FAIL;
      end
      ST_AVG:    state_d = ST_CHECK;
      ST_CHECK:  if (ch_last) state_d = ST_DONE;
      ST_FAIL:   state_d = ST_DONE;
      ST_DONE:   if (start) state_d = ST_ENABLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE));
    done         = (state_q == ST_DONE);
    sensor_start = (state_q == ST_ENABLE) || (state_q == ST_WARMUP) ||
                   (state_q == ST_ACCUM);
    // After a timeout the sensor stays in reset while DONE holds.
    sensor_reset = (state_q == ST_IDLE) || (state_q == ST_FAIL) ||
                   ((state_q == ST_DONE) && error_timeout_q);
    reset_1sec   = (state_d != state_q);
  end

  // Counters, timer and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q           <= '0;
      timer_q         <= '0;
      ch_idx_q        <= '0;
      offsets_q       <= '0;
      offsets_valid_q <= 1'b0;
      error_timeout_q <= 1'b0;
      error_range_q   <= '0;
    end else begin
      case (state_q)
        ST_ENABLE: begin
          cnt_q           <= '0;
          timer_q         <= '0;
          ch_idx_q        <= '0;
          offsets_valid_q <= 1'b0;
          error_timeout_q <= 1'b0;
          error_range_q   <= '0;
        end
        ST_WARMUP: begin
          if (en_sec) timer_q <= timer_q + 1'b1;
          if (state_d == ST_ACCUM) cnt_q <= '0;
          else if (sample_valid)   cnt_q <= cnt_q + 1'b1;
        end
        ST_ACCUM: begin
          if (en_sec)       timer_q <= timer_q + 1'b1;
          if (sample_valid) cnt_q   <= cnt_q + 1'b1;
        end
        ST_AVG: begin
          offsets_q <= avg_all;
          ch_idx_q  <= '0;
        end
        ST_CHECK: begin
          error_range_q <= error_range_d;
          ch_idx_q      <= ch_idx_q + 1'b1;
          if (ch_last) offsets_valid_q <= ~|error_range_d;
        end
        ST_FAIL: begin
          error_timeout_q <= 1'b1;
          offsets_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign offsets       = offsets_q;
  assign offsets_valid = offsets_valid_q;
  assign error_timeout = error_timeout_q;
  assign error_range   = error_range_q;

endmodule
